sram_controller: RTL

Responder side of the MEM-stage memory interface. The pipeline's memory stage issues read/write requests (address = ALU result, write data = Rm value). This block serves them from an external 16-bit asynchronous SRAM, splitting each 32-bit word into two half-word accesses. It holds `ready` low until the access completes, and the core uses `~ready` as a freeze for every pipeline register.

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_wait_counter.sv | 31 +++
 rtl/sram_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the MEM-stage SRAM controller.
//   state_t             - controller FSM states (IDLE, LOW, HIGH, DONE)
//   DATA_BASE_ADDR      - byte address of the data segment; subtracted from the
//                         request address when SRAM_CTRL_ADDR_OFFSET_EN is defined
//   DEFAULT_WAIT_CYCLES - default extra hold cycles per half-word access
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DATA_BASE_ADDR      = 32'd1024;
  localparam int          DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: 3-bit down-counter timing how long each half-word access
// is held on the SRAM bus.
//   clk      - clock
//   rst      - asynchronous active-low reset (count cleared)
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value loaded on each FSM state entry
//   tc       - terminal count: the count has reached zero
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       tc
);

  logic [2:0] count;

  // Saturates at zero; the FSM reloads it whenever it changes state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign tc = (count == 3'd0);

endmodule

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit MEM-stage loads/stores from a 16-bit
// asynchronous SRAM as two half-word accesses (low half, then high half).
// ready stays low until the access completes; the core freezes on ~ready.
//   clk, rst          - clock, asynchronous active-low reset
//   mem_r_en/mem_w_en - read/write request levels, held until ready
//   addr, wdata       - byte address and store data
//   rdata             - registered load data, valid in the ready cycle
//   ready             - access complete / nothing pending
//   sram_addr         - half-word address to the SRAM
//   sram_dq_out/_in   - SRAM data bus out/in, sram_dq_oe enables the driver
//   sram_we_n         - active-low SRAM write strobe
// Optional macro SRAM_CTRL_ADDR_OFFSET_EN: when defined, DATA_BASE_ADDR is
// subtracted from addr so the data segment starts at SRAM address 0.
module sram_controller
  import sram_pkg::*;
#(
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                 state, state_next;
  logic                   is_write_q;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [31:0]            wdata_q;
  logic [31:0]            eff_addr;
  logic                   tc;
  logic                   req;
  logic                   upper;
  logic                   driving;

  assign req = mem_r_en | mem_w_en;

`ifdef SRAM_CTRL_ADDR_OFFSET_EN
  assign eff_addr = addr - DATA_BASE_ADDR;
`else
  assign eff_addr = addr;
`endif

  // Byte-lane bits and bits above the SRAM size are dropped: word accesses
  // only, and addresses wrap modulo the SRAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{eff_addr[31:SRAM_ADDR_W+1], eff_addr[1:0]};

  sram_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (state_next != state),
    .load_val (3'(WAIT_CYCLES)),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = LOW;
      LOW:     if (tc)  state_next = HIGH;
      HIGH:    if (tc)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; a simultaneous read and write is treated as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= 32'd0;
    end else if (state == IDLE && req) begin
      is_write_q <= mem_w_en;
      word_q     <= eff_addr[SRAM_ADDR_W:2];
      wdata_q    <= wdata;
    end
  end

  // Each half is captured on the edge that leaves its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= 32'd0;
    end else if (!is_write_q && tc) begin
      if (state == LOW) begin
        rdata[15:0] <= sram_dq_in;
      end else if (state == HIGH) begin
        rdata[31:16] <= sram_dq_in;
      end
    end
  end

  // Bus outputs decode from registered state, so reset drops the strobe
  // and the driver immediately.
  always_comb begin
    upper       = 1'b0;
    driving     = 1'b0;
    sram_dq_out = wdata_q[15:0];
    if (state == HIGH) begin
      upper       = 1'b1;
      sram_dq_out = wdata_q[31:16];
    end
    if ((state == LOW || state == HIGH) && is_write_q) begin
      driving = 1'b1;
    end
    sram_addr  = {word_q, upper};
    sram_dq_oe = driving;
    sram_we_n  = ~driving;
  end

  assign ready = ~req | (state == DONE);

endmodule
